// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the fetch stage and control unit.
// The ILLEGAL_OPCODE_CHECK_EN macro adds an illegal flag to each fetch entry.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
`ifdef ILLEGAL_OPCODE_CHECK_EN
        logic            illegal;
`endif
    } fetch_entry_t;

    // Low two opcode bits must be 2'b11 (32-bit encoding) and the major opcode supported.
    function automatic logic opcode_illegal(input logic [6:0] op);
        return (op[1:0] != 2'b11) ||
               !(op inside {OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_JALR, OP_JAL});
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a flush that overrides push and pop.
// Entry layout depends on ILLEGAL_OPCODE_CHECK_EN through fetch_entry_t.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count_next_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !flush && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next_c = count;
        if (flush) begin
            count_next_c = '0;
        end else begin
            count_next_c = count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= count_next_c;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= wdata;
                    wr_ptr      <= AW'(wr_ptr + 1'b1);
                end
                if (do_pop) begin
                    rd_ptr <= AW'(rd_ptr + 1'b1);
                end
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch: owns the PC, one outstanding imem request, buffered hand-off to decode.
// Define ILLEGAL_OPCODE_CHECK_EN to add the if_illegal output.
module instr_fetch #(
    parameter int unsigned         XLEN       = 32,
    parameter logic [XLEN-1:0]     RESET_PC   = '0,
    parameter int unsigned         FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [XLEN-1:0]     imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [XLEN-1:0]     if_pc,
    output logic [XLEN-1:0]     if_instr,
`ifdef ILLEGAL_OPCODE_CHECK_EN
    output logic                if_illegal,
`endif
    output logic [6:0]          if_opcode
);

    import rv_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       state;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_inc;
    logic [XLEN-1:0]    redir_target;
    logic               fire;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               slot_free_next;
    logic [CW-1:0]      count_next;
    fetch_entry_t       wr_entry;
    fetch_entry_t       head;

    assign pc_inc         = pc + XLEN'(4);
    // Low address bits of the target are forced to zero.
    assign redir_target   = {redirect_pc[XLEN-1:2], redirect_pc[1:0] & 2'b00};
    assign fire           = imem_req_valid && imem_req_ready;
    assign push           = (state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop            = if_valid && if_ready;
    assign slot_free_next = (count_next < CW'(FIFO_DEPTH));

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = pc;
        wr_entry.instr = imem_rsp_data;
`ifdef ILLEGAL_OPCODE_CHECK_EN
        wr_entry.illegal = opcode_illegal(imem_rsp_data[6:0]);
`endif
    end

    fetch_fifo #(
        .DEPTH        (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .flush        (redirect_valid),
        .wdata        (wr_entry),
        .rdata        (head),
        .empty        (fifo_empty),
        .count_next_c (count_next)
    );

    assign if_valid  = !fifo_empty;
    assign if_pc     = head.pc;
    assign if_instr  = head.instr;
    assign if_opcode = head.instr[6:0];
`ifdef ILLEGAL_OPCODE_CHECK_EN
    assign if_illegal = head.illegal;
`endif

    // Fetch FSM; request valid/address are registered from the next-cycle state and FIFO occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_PC;
        end else if (redirect_valid) begin
            pc            <= redir_target;
            imem_req_addr <= redir_target;
            case (state)
                IDLE: begin
                    // A request accepted this cycle still owes a response, which must be dropped.
                    state          <= fire ? DROP : IDLE;
                    imem_req_valid <= !fire;
                end
                default: begin
                    state          <= imem_rsp_valid ? IDLE : DROP;
                    imem_req_valid <= imem_rsp_valid;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                    end else begin
                        imem_req_valid <= slot_free_next;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state          <= IDLE;
                        pc             <= pc_inc;
                        imem_req_addr  <= pc_inc;
                        imem_req_valid <= slot_free_next;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state          <= IDLE;
                        imem_req_valid <= slot_free_next;
                    end
                end
                default: begin
                    state          <= IDLE;
                    imem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a variable-latency instruction memory model.
// Build with ILLEGAL_OPCODE_CHECK_EN to also check if_illegal.
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;
`ifdef ILLEGAL_OPCODE_CHECK_EN
    logic        if_illegal;
`endif

    instr_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
`ifdef ILLEGAL_OPCODE_CHECK_EN
        .if_illegal     (if_illegal),
`endif
        .if_opcode      (if_opcode)
    );

    int          n_checks = 0;
    int          n_fail   = 0;

    // Memory model configuration (written by the stimulus process only)
    int          lat = 1;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_data = '0;
    bit          redir_on_rsp = 1'b0;
    int          redir_req_cnt = 0;
    logic [31:0] redir_target = '0;

    // Memory model state
    bit          pend = 1'b0;
    int          cnt = 0;
    int          redir_done = 0;
    logic [31:0] rsp_addr = '0;
    logic [31:0] reqlog[$];
    logic [63:0] cons[$];

    // Memory: drives response/redirect mid-cycle so the DUT samples them on the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            pend = 1'b0;
            imem_rsp_valid = 1'b0;
            redirect_valid = 1'b0;
            reqlog.delete();
        end else begin
            imem_rsp_valid = 1'b0;
            redirect_valid = 1'b0;
            if (redir_done != redir_req_cnt) begin
                redirect_valid = 1'b1;
                redirect_pc    = redir_target;
                redir_done     = redir_req_cnt;
            end
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    pend           = 1'b0;
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = use_fixed ? fixed_data : rsp_addr + 32'h13;
                    if (redir_on_rsp) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = redir_target;
                    end
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                pend     = 1'b1;
                cnt      = lat;
                rsp_addr = imem_req_addr;
                reqlog.push_back(imem_req_addr);
            end
        end
    end

    // Decode side: record every consumed instruction.
    always @(posedge clk) begin
        if (reset) cons.delete();
        else if (if_valid && if_ready) cons.push_back({if_pc, if_instr});
    end

    function automatic logic [31:0] req_at(input int i);
        return (i < reqlog.size()) ? reqlog[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] cons_pc(input int i);
        logic [63:0] e;
        e = (i < cons.size()) ? cons[i] : 64'hDEAD_BEEF_DEAD_BEEF;
        return e[63:32];
    endfunction

    function automatic logic [31:0] cons_instr(input int i);
        logic [63:0] e;
        e = (i < cons.size()) ? cons[i] : 64'hDEAD_BEEF_DEAD_BEEF;
        return e[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic restart(input int l);
        lat = l;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_reqs(input int n, input string tag);
        for (int i = 0; i < 300 && reqlog.size() < n; i++) @(negedge clk);
        check({tag, "_req_cnt"}, 32'(reqlog.size() >= n), 32'd1);
    endtask

    task automatic wait_cons(input int n, input string tag);
        for (int i = 0; i < 300 && cons.size() < n; i++) @(negedge clk);
        check({tag, "_cons_cnt"}, 32'(cons.size() >= n), 32'd1);
    endtask

    task automatic wait_if_valid(input string tag);
        for (int i = 0; i < 300 && !if_valid; i++) @(negedge clk);
        check({tag, "_if_valid"}, 32'(if_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_req_addr"},  imem_req_addr, 32'h0);
        check({tag, "_if_valid"},  32'(if_valid), 32'd0);
        check({tag, "_if_pc"},     if_pc, 32'h0);
        check({tag, "_if_instr"},  if_instr, 32'h0);
        check({tag, "_if_opcode"}, 32'(if_opcode), 32'h0);
    endtask

    initial begin
        bit hit;

        // Reset values
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");

        // Streaming with 1-cycle memory and decode always ready
        if_ready = 1'b1;
        lat      = 1;
        reset    = 1'b0;
        @(posedge clk);
        #1 check("t1_first_req", 32'(imem_req_valid), 32'd1);
        check("t1_first_addr", imem_req_addr, 32'h0);
        wait_reqs(3, "t1");
        for (int i = 0; i < 3; i++) check($sformatf("t1_req%0d", i), req_at(i), 32'(4 * i));
        wait_cons(3, "t1");
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_pc%0d", i), cons_pc(i), 32'(4 * i));
            check($sformatf("t1_instr%0d", i), cons_instr(i), 32'(4 * i) + 32'h13);
        end

        // Decode stalled: FIFO fills to two entries and requests stop
        if_ready = 1'b0;
        restart(1);
        repeat (12) @(negedge clk);
        check("t2_req_cnt", 32'(reqlog.size()), 32'd2);
        check("t2_req_valid", 32'(imem_req_valid), 32'd0);
        check("t2_if_valid", 32'(if_valid), 32'd1);
        check("t2_head_pc", if_pc, 32'h0);
        check("t2_head_instr", if_instr, 32'h13);
        check("t2_head_opcode", 32'(if_opcode), 32'h13);
        check("t2_no_cons", 32'(cons.size()), 32'd0);
        if_ready = 1'b1;
        wait_cons(3, "t2");
        for (int i = 0; i < 3; i++) check($sformatf("t2_pc%0d", i), cons_pc(i), 32'(4 * i));
        check("t2_resume_addr", req_at(2), 32'h8);

        // Redirect while waiting on a 3-cycle response
        if_ready     = 1'b1;
        redir_target = 32'h100;
        restart(3);
        wait_reqs(1, "t3a");
        @(negedge clk);
        redir_req_cnt++;
        wait_reqs(2, "t3b");
        check("t3_redir_addr", req_at(1), 32'h100);
        wait_cons(1, "t3");
        check("t3_first_pc", cons_pc(0), 32'h100);
        check("t3_first_instr", cons_instr(0), 32'h113);

        // Redirect coincident with the response; buffered entry is flushed
        if_ready     = 1'b0;
        redir_target = 32'h203;
        restart(3);
        wait_reqs(2, "t4a");
        redir_on_rsp = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk);
            if (redirect_valid && imem_rsp_valid) hit = 1'b1;
        end
        redir_on_rsp = 1'b0;
        check("t4_coincide", 32'(hit), 32'd1);
        #1;
        check("t4_flushed", 32'(if_valid), 32'd0);
        check("t4_req_valid", 32'(imem_req_valid), 32'd1);
        check("t4_req_addr", imem_req_addr, 32'h200);
        wait_reqs(3, "t4b");
        check("t4_next_addr", req_at(2), 32'h200);
        if_ready = 1'b1;
        wait_cons(1, "t4");
        check("t4_first_pc", cons_pc(0), 32'h200);
        check("t4_first_instr", cons_instr(0), 32'h213);

        // Asynchronous reset in the middle of a wait
        if_ready = 1'b0;
        restart(3);
        wait_reqs(2, "t5a");
        @(negedge clk);
        check("t5_pre_valid", 32'(if_valid), 32'd1);
        check("t5_pre_addr", imem_req_addr, 32'h4);
        reset = 1'b1;
        #1;
        check_reset_outputs("t5");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_reqs(1, "t5b");
        check("t5_first_addr", req_at(0), 32'h0);

        // Opcode pass-through and optional illegal flag
        use_fixed  = 1'b1;
        fixed_data = 32'h0000_007F;
        restart(1);
        wait_if_valid("t6a");
        check("t6_opcode_7f", 32'(if_opcode), 32'h7F);
`ifdef ILLEGAL_OPCODE_CHECK_EN
        check("t6_illegal_7f", 32'(if_illegal), 32'd1);
`endif
        fixed_data = 32'h0000_0033;
        restart(1);
        wait_if_valid("t6b");
        check("t6_opcode_33", 32'(if_opcode), 32'h33);
`ifdef ILLEGAL_OPCODE_CHECK_EN
        check("t6_illegal_33", 32'(if_illegal), 32'd0);
`endif
        use_fixed = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
